// File: rtl/lc3_mem_pkg.sv
// Shared types for the LC-3 memory arbiter: FSM state encoding and requester IDs.
package lc3_mem_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_LDR = 1'b1;

endpackage

// File: rtl/lc3_rr_arb2.sv
// Combinational 2-way round-robin picker; bit 0 = CPU, bit 1 = loader.
module lc3_rr_arb2
  import lc3_mem_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic       o_grant_c
);

  // On contention the requester that did not win last time goes first.
  always_comb begin
    o_grant_c = REQ_CPU;
    if (&i_req) begin
      o_grant_c = ~i_last_grant;
    end else if (i_req[1]) begin
      o_grant_c = REQ_LDR;
    end
  end

endmodule

// File: rtl/lc3_mem_arbiter.sv
// Sequences LC-3 memory cycles and shares the single-port memory between the
// CPU control FSM and the program loader (IDLE -> ACCESS -> DONE).
module lc3_mem_arbiter
  import lc3_mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic [DATA_W-1:0] o_cpu_rdata,
  output logic              o_cpu_ready,
  input  logic              i_ldr_req,
  input  logic              i_ldr_we,
  input  logic [ADDR_W-1:0] i_ldr_addr,
  input  logic [DATA_W-1:0] i_ldr_wdata,
  output logic [DATA_W-1:0] o_ldr_rdata,
  output logic              o_ldr_ready,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_busy
);

  localparam int unsigned CNT_W = $clog2(WAIT_CYCLES + 1);

  if (WAIT_CYCLES == 0) begin : g_bad_wait
    $error("lc3_mem_arbiter: WAIT_CYCLES must be at least 1");
  end

  state_e            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_last_grant;
  logic              r_grant;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_ldr_rdata;
  logic              r_cpu_ready;
  logic              r_ldr_ready;
  logic              r_busy;

  logic              w_grant;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  lc3_rr_arb2 u_arb (
    .i_req        ({i_ldr_req, i_cpu_req}),
    .i_last_grant (r_last_grant),
    .o_grant_c    (w_grant)
  );

  assign w_sel_we    = (w_grant == REQ_LDR) ? i_ldr_we    : i_cpu_we;
  assign w_sel_addr  = (w_grant == REQ_LDR) ? i_ldr_addr  : i_cpu_addr;
  assign w_sel_wdata = (w_grant == REQ_LDR) ? i_ldr_wdata : i_cpu_wdata;

  // Single-process FSM; every output is a register updated alongside the state.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_last_grant <= REQ_LDR;
      r_grant      <= REQ_CPU;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_cpu_rdata  <= '0;
      r_ldr_rdata  <= '0;
      r_cpu_ready  <= 1'b0;
      r_ldr_ready  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_cpu_ready <= 1'b0;
      r_ldr_ready <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_cpu_req || i_ldr_req) begin
            r_grant      <= w_grant;
            r_last_grant <= w_grant;
            r_cnt        <= CNT_W'(WAIT_CYCLES - 1);
            r_mem_en     <= 1'b1;
            r_mem_we     <= w_sel_we;
            r_mem_addr   <= w_sel_addr;
            r_mem_wdata  <= w_sel_wdata;
            r_busy       <= 1'b1;
            r_state      <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (r_cnt == '0) begin
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
            r_state  <= ST_DONE;
            if (r_grant == REQ_LDR) begin
              r_ldr_ready <= 1'b1;
              if (!r_mem_we) r_ldr_rdata <= i_mem_rdata;
            end else begin
              r_cpu_ready <= 1'b1;
              if (!r_mem_we) r_cpu_rdata <= i_mem_rdata;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_cpu_rdata = r_cpu_rdata;
  assign o_cpu_ready = r_cpu_ready;
  assign o_ldr_rdata = r_ldr_rdata;
  assign o_ldr_ready = r_ldr_ready;
  assign o_mem_en    = r_mem_en;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Self-checking bench for lc3_mem_arbiter: directed scenarios plus randomized
// traffic compared every cycle against a transaction-window reference model.
module tb_lc3_mem_arbiter;

  localparam int W = 2;

  logic        clk;
  logic        rst_n;
  logic        cpu_req, cpu_we, ldr_req, ldr_we;
  logic [15:0] cpu_addr, cpu_wdata, ldr_addr, ldr_wdata;
  logic [15:0] cpu_rdata, ldr_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_ready, ldr_ready, mem_en, mem_we, busy;

  int n_chk  = 0;
  int n_pass = 0;

  lc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(W)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_cpu_req   (cpu_req),
    .i_cpu_we    (cpu_we),
    .i_cpu_addr  (cpu_addr),
    .i_cpu_wdata (cpu_wdata),
    .o_cpu_rdata (cpu_rdata),
    .o_cpu_ready (cpu_ready),
    .i_ldr_req   (ldr_req),
    .i_ldr_we    (ldr_we),
    .i_ldr_addr  (ldr_addr),
    .i_ldr_wdata (ldr_wdata),
    .o_ldr_rdata (ldr_rdata),
    .o_ldr_ready (ldr_ready),
    .o_mem_en    (mem_en),
    .o_mem_we    (mem_we),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .i_mem_rdata (mem_rdata),
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, act, exp);
    else n_pass++;
  endtask

  // Reference model: a granted transaction owns cycles [st, st+W-1] for memory
  // and cycle st+W for the ready pulse; the model is idle otherwise.
  int          c = 0;
  bit          m_valid = 0;
  bit          m_act = 0;
  int          m_st = 0;
  logic        m_g = 1'b0, m_we = 1'b0, m_last = 1'b1;
  logic [15:0] m_addr = '0, m_wd = '0, m_crd = '0, m_lrd = '0;

  always @(negedge clk) begin
    bit e_en, e_rdy;
    if (m_valid) begin
      e_en  = m_act && (c < m_st + W);
      e_rdy = m_act && (c == m_st + W);
      chk("mem_en", mem_en, e_en);
      chk("mem_we", mem_we, e_en & m_we);
      chk("busy", busy, m_act);
      chk("cpu_ready", cpu_ready, e_rdy && (m_g == 1'b0));
      chk("ldr_ready", ldr_ready, e_rdy && (m_g == 1'b1));
      chk("cpu_rdata", cpu_rdata, m_crd);
      chk("ldr_rdata", ldr_rdata, m_lrd);
      if (e_en) begin
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wdata", mem_wdata, m_wd);
      end
    end
    if (!rst_n) begin
      m_valid = 1; m_act = 0; m_last = 1'b1; m_crd = '0; m_lrd = '0;
    end else if (m_valid) begin
      if (m_act) begin
        if (c == m_st + W - 1 && !m_we) begin
          if (m_g) m_lrd = mem_rdata; else m_crd = mem_rdata;
        end
        if (c == m_st + W) m_act = 0;
      end else if (cpu_req || ldr_req) begin
        if (cpu_req && ldr_req) m_g = ~m_last;
        else m_g = ldr_req;
        m_last = m_g;
        m_act  = 1;
        m_st   = c + 1;
        m_we   = m_g ? ldr_we    : cpu_we;
        m_addr = m_g ? ldr_addr  : cpu_addr;
        m_wd   = m_g ? ldr_wdata : cpu_wdata;
      end
    end
    c++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic who, input logic req, input logic we,
                       input logic [15:0] a, input logic [15:0] wd);
    if (who) begin ldr_req = req; ldr_we = we; ldr_addr = a; ldr_wdata = wd; end
    else     begin cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = wd; end
  endtask

  // One transaction by one requester; reports mem_en cycles, ready latency and
  // whether the memory bus carried the requested access throughout.
  task automatic do_txn(input logic who, input logic we, input logic [15:0] a,
                        input logic [15:0] wd, output int en_n, output int rdy_k,
                        output bit bus_ok);
    en_n = 0; rdy_k = -1; bus_ok = 1;
    drive(who, 1'b1, we, a, wd);
    for (int k = 1; k <= 20 && rdy_k < 0; k++) begin
      tick;
      if (mem_en) begin
        en_n++;
        if (mem_we !== we || mem_addr !== a || mem_wdata !== wd) bus_ok = 0;
      end
      if ((who ? ldr_ready : cpu_ready) === 1'b1) rdy_k = k;
    end
    drive(who, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    int en_n, rdy_k, n, cpu_k, ldr_k;
    bit bus_ok;
    int ord[4];
    int at[4];

    rst_n = 1'b0; mem_rdata = 16'h1234;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    repeat (3) tick;
    rst_n = 1'b1;

    // Idle after reset: everything stays at zero.
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("t1_idle_outputs", {busy, mem_en, mem_we, cpu_ready, ldr_ready, cpu_rdata, ldr_rdata}, '0);
    end

    do_txn(1'b0, 1'b0, 16'h3000, 16'h0000, en_n, rdy_k, bus_ok);
    chk("t2_en_cycles", 32'(en_n), 32'd2);
    chk("t2_latency", 32'(rdy_k), 32'd3);
    chk("t2_cpu_rdata", cpu_rdata, 16'h1234);
    chk("t2_ldr_rdata", ldr_rdata, 16'h0000);
    chk("t2_bus", 32'(bus_ok), 32'd1);
    tick;

    do_txn(1'b1, 1'b1, 16'h0200, 16'hBEEF, en_n, rdy_k, bus_ok);
    chk("t3_en_cycles", 32'(en_n), 32'd2);
    chk("t3_latency", 32'(rdy_k), 32'd3);
    chk("t3_write_bus", 32'(bus_ok), 32'd1);
    chk("t3_ldr_rdata_kept", ldr_rdata, 16'h0000);
    chk("t3_cpu_rdata_kept", cpu_rdata, 16'h1234);
    tick;

    // Both requesters held continuously: alternate grants every 4 cycles.
    for (int i = 0; i < 4; i++) begin ord[i] = -1; at[i] = -1; end
    n = 0;
    drive(1'b0, 1'b1, 1'b0, 16'h3001, 16'h0);
    drive(1'b1, 1'b1, 1'b0, 16'h0201, 16'h0);
    for (int k = 1; k <= 40 && n < 4; k++) begin
      tick;
      if (cpu_ready) begin ord[n] = 0; at[n] = k; n++; end
      if (ldr_ready && n < 4) begin ord[n] = 1; at[n] = k; n++; end
    end
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    chk("t4_count", 32'(n), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t4_order", 32'(ord[i]), 32'(i % 2));
      chk("t4_spacing", 32'(at[i]), 32'(3 + 4 * i));
    end
    tick;

    // Reset during the second ACCESS cycle aborts the access.
    drive(1'b0, 1'b1, 1'b0, 16'h3002, 16'h0);
    tick; tick;
    chk("t5_in_access", 32'(mem_en), 32'd1);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    chk("t5_abort", {mem_en, cpu_ready, busy}, 3'b000);
    chk("t5_rdata_cleared", cpu_rdata, 16'h0000);
    rdy_k = -1;
    for (int k = 1; k <= 10 && rdy_k < 0; k++) begin
      tick;
      if (cpu_ready) rdy_k = k;
    end
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    chk("t5_restart_latency", 32'(rdy_k), 32'd3);
    chk("t5_restart_rdata", cpu_rdata, 16'h1234);
    tick;

    // CPU drops its request mid-ACCESS while the loader starts waiting.
    cpu_k = -1; ldr_k = -1;
    drive(1'b0, 1'b1, 1'b0, 16'h3003, 16'h0);
    for (int k = 1; k <= 12 && ldr_k < 0; k++) begin
      tick;
      if (k == 1) begin
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b1, 1'b0, 16'h0203, 16'h0);
      end
      if (cpu_ready) cpu_k = k;
      if (ldr_ready) begin ldr_k = k; drive(1'b1, 1'b0, 1'b0, '0, '0); end
    end
    chk("t6_cpu_ready", 32'(cpu_k), 32'd3);
    chk("t6_ldr_next", 32'(ldr_k), 32'd7);
    tick;

    // Randomized traffic with occasional resets and mid-access drops.
    for (int i = 0; i < 600; i++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      mem_rdata = 16'($urandom);
      if (cpu_req && cpu_ready) begin
        drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom), 16'($urandom), 16'($urandom));
      end else if (!cpu_req && $urandom_range(0, 2) == 0) begin
        drive(1'b0, 1'b1, 1'($urandom), 16'($urandom), 16'($urandom));
      end else if (cpu_req && $urandom_range(0, 49) == 0) begin
        cpu_req = 1'b0;
      end
      if (ldr_req && ldr_ready) begin
        drive(1'b1, 1'($urandom_range(0, 1)), 1'($urandom), 16'($urandom), 16'($urandom));
      end else if (!ldr_req && $urandom_range(0, 2) == 0) begin
        drive(1'b1, 1'b1, 1'($urandom), 16'($urandom), 16'($urandom));
      end else if (ldr_req && $urandom_range(0, 49) == 0) begin
        ldr_req = 1'b0;
      end
      tick;
    end
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    repeat (6) tick;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
